// File: rtl/pulse_period_monitor.sv
// Receive-side checker for a periodic one-cycle pulse train: tracks spacing,
// declares lock after LOCK good periods, and latches early/late faults.
module pulse_period_monitor #(
  parameter int unsigned N     = 20000,
  parameter int unsigned CBITS = 15,
  parameter int unsigned LOCK  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic       clr,
  output logic       locked,
  output logic       fault,
  output logic       fault_late,
  output logic [1:0] state,
  output logic [7:0] fault_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10,
    FAULT  = 2'b11
  } state_t;

  localparam logic [CBITS-1:0] CNT_MAX  = CBITS'(N);
  localparam logic [7:0]       GOOD_MAX = 8'(LOCK);

  state_t           r_state;
  logic [CBITS-1:0] r_cnt;
  logic [7:0]       r_good;
  logic             r_locked;
  logic             r_fault;
  logic             r_fault_late;
  logic [7:0]       r_fault_cnt;

  logic [7:0]       w_good_next;
  logic [7:0]       w_fault_cnt_next;
  logic             w_at_max;

  // Saturating next values for the good-period and fault counters
  always_comb begin
    w_good_next      = (r_good >= GOOD_MAX) ? GOOD_MAX : r_good + 8'd1;
    w_fault_cnt_next = (r_fault_cnt == 8'hFF) ? r_fault_cnt : r_fault_cnt + 8'd1;
    w_at_max         = (r_cnt == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_good       <= '0;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_late <= 1'b0;
      r_fault_cnt  <= '0;
    end else if (clr) begin
      // Re-arm: any pulse on this edge is dropped
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sig) begin
            r_state <= TRACK;
            r_cnt   <= '0;
            r_good  <= '0;
          end
        end
        TRACK, LOCKED: begin
          if (sig) begin
            if (w_at_max) begin
              r_cnt  <= '0;
              r_good <= w_good_next;
              if (w_good_next == GOOD_MAX) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end else begin
                r_state  <= TRACK;
              end
            end else begin
              r_state      <= FAULT;
              r_fault      <= 1'b1;
              r_fault_late <= 1'b0;
              r_locked     <= 1'b0;
              r_cnt        <= '0;
              r_good       <= '0;
              r_fault_cnt  <= w_fault_cnt_next;
            end
          end else if (w_at_max) begin
            // Expected pulse did not arrive
            r_state      <= FAULT;
            r_fault      <= 1'b1;
            r_fault_late <= 1'b1;
            r_locked     <= 1'b0;
            r_cnt        <= '0;
            r_good       <= '0;
            r_fault_cnt  <= w_fault_cnt_next;
          end else begin
            r_cnt <= r_cnt + CBITS'(1);
          end
        end
        default: begin
          r_cnt    <= '0;
          r_good   <= '0;
          r_locked <= 1'b0;
          r_fault  <= 1'b1;
        end
      endcase
    end
  end

  assign locked     = r_locked;
  assign fault      = r_fault;
  assign fault_late = r_fault_late;
  assign state      = r_state;
  assign fault_cnt  = r_fault_cnt;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Bench for pulse_period_monitor (N=4, LOCK=3): timestamp-based reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_pulse_period_monitor;

  localparam int N    = 4;
  localparam int LOCK = 3;

  logic       clk;
  logic       rst;
  logic       sig;
  logic       clr;
  logic       locked;
  logic       fault;
  logic       fault_late;
  logic [1:0] state;
  logic [7:0] fault_cnt;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 idle, 1 tracking, 2 faulted; spacing measured by timestamps
  int m_mode, m_cyc, m_last, m_good, m_fcnt;
  bit m_late;

  pulse_period_monitor #(.N(N), .CBITS(3), .LOCK(LOCK)) dut (
    .clk(clk), .rst(rst), .sig(sig), .clr(clr),
    .locked(locked), .fault(fault), .fault_late(fault_late),
    .state(state), .fault_cnt(fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cyc = 0; m_last = 0; m_good = 0; m_fcnt = 0; m_late = 1'b0;
  endtask

  task automatic model_fault(input bit late);
    m_mode = 2;
    m_good = 0;
    m_late = late;
    if (m_fcnt < 255) m_fcnt++;
  endtask

  task automatic model_step(input bit s, input bit c);
    int d;
    m_cyc++;
    d = m_cyc - m_last;
    if (c) begin
      m_mode = 0;
      m_good = 0;
    end else if (m_mode == 0) begin
      if (s) begin
        m_mode = 1; m_last = m_cyc; m_good = 0;
      end
    end else if (m_mode == 1) begin
      if (s) begin
        if (d == N + 1) begin
          m_good = (m_good + 1 > LOCK) ? LOCK : m_good + 1;
          m_last = m_cyc;
        end else begin
          model_fault(1'b0);
        end
      end else if (d == N + 1) begin
        model_fault(1'b1);
      end
    end
  endtask

  // Compare all outputs against the model
  task automatic compare_all();
    bit   exp_locked;
    logic [1:0] exp_state;
    exp_locked = (m_mode == 1) && (m_good == LOCK);
    exp_state  = (m_mode == 0) ? 2'b00 : (m_mode == 2) ? 2'b11 : (exp_locked ? 2'b10 : 2'b01);
    check("model_state", 32'(state), 32'(exp_state));
    check("model_locked", 32'(locked), 32'(exp_locked));
    check("model_fault", 32'(fault), 32'(m_mode == 2));
    check("model_fault_late", 32'(fault_late), 32'(m_late));
    check("model_fault_cnt", 32'(fault_cnt), 32'(m_fcnt));
  endtask

  // Drive inputs for one cycle (called at negedge), check after the edge
  task automatic tick(input bit s, input bit c);
    sig = s;
    clr = c;
    @(posedge clk);
    if (rst) model_step(s, c);
    @(negedge clk);
    compare_all();
  endtask

  task automatic gap_pulse(input int zeros);
    for (int i = 0; i < zeros; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; sig = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_flags", {29'd0, locked, fault, fault_late}, 32'd0);
    check("reset_fcnt", 32'(fault_cnt), 32'd0);
    rst = 1'b1;

    // 1: pulses at cycles 10,15,20,25
    gap_pulse(9);
    check("t1_track", 32'(state), 32'd1);
    gap_pulse(4);
    gap_pulse(4);
    check("t1_not_yet_locked", 32'(locked), 32'd0);
    gap_pulse(4);
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_state_locked", 32'(state), 32'd2);
    check("t1_no_fault", 32'(fault), 32'd0);

    // 2: early pulse at +3
    gap_pulse(4);
    gap_pulse(2);
    check("t2_fault", 32'(fault), 32'd1);
    check("t2_early", 32'(fault_late), 32'd0);
    check("t2_unlocked", 32'(locked), 32'd0);
    check("t2_fcnt", 32'(fault_cnt), 32'd1);
    tick(1'b1, 1'b0);
    check("t2_sig_ignored_in_fault", 32'(fault_cnt), 32'd1);

    // 4: clr with sig in FAULT drops the pulse
    tick(1'b1, 1'b1);
    check("t4_idle", 32'(state), 32'd0);
    check("t4_fault_cleared", 32'(fault), 32'd0);
    gap_pulse(3);
    check("t4_track", 32'(state), 32'd1);
    check("t4_fcnt_kept", 32'(fault_cnt), 32'd1);

    // 3: lock, then withhold the pulse
    gap_pulse(4); gap_pulse(4); gap_pulse(4);
    check("t3_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    check("t3_still_locked", 32'(locked), 32'd1);
    tick(1'b0, 1'b0);
    check("t3_fault", 32'(fault), 32'd1);
    check("t3_late", 32'(fault_late), 32'd1);
    check("t3_fcnt", 32'(fault_cnt), 32'd2);

    // 5: sig held high two cycles from TRACK, then saturate the counter
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("t5_early_fault", 32'(state), 32'd3);
    check("t5_early_flag", 32'(fault_late), 32'd0);
    check("t5_fcnt", 32'(fault_cnt), 32'd3);
    for (int i = 0; i < 256; i++) begin
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
    end
    check("t5_fcnt_sat", 32'(fault_cnt), 32'd255);

    // 6: async reset while LOCKED, between edges
    tick(1'b0, 1'b1);
    gap_pulse(0); gap_pulse(4); gap_pulse(4); gap_pulse(4);
    check("t6_locked", 32'(locked), 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("t6_async_state", 32'(state), 32'd0);
    check("t6_async_flags", {29'd0, locked, fault, fault_late}, 32'd0);
    check("t6_async_fcnt", 32'(fault_cnt), 32'd0);
    @(negedge clk);
    tick(1'b1, 1'b0);
    rst = 1'b1;
    gap_pulse(2);
    gap_pulse(4);
    check("t6_retrack", 32'(state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
